bcd_counter_ndigit: RTL and testbench

Parametrised multi-digit BCD counter: the general-purpose successor to the single-digit decade counter in the sequential-logic library. It counts up or down in packed BCD across `DIGITS` decimal digits and supports synchronous clear, parallel load with digit validation, and chained carry/borrow. It drives multi-digit displays, event tallies and timers, and cascades with other instances through `tc`.

---
 rtl/bcd_counter_ndigit.sv | 137 +++++++++++++
 tb/tb_bcd_counter_ndigit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_ndigit.sv
// -----------------------------------------------------------------------------
// bcd_counter_ndigit
//
// Multi-digit packed-BCD up/down counter. It supports synchronous clear,
// parallel load with per-digit validation, and a terminal-count output for
// cascading. Digit k occupies bits [4k+3:4k]. Digit 0 is least significant.
//
// Ports
//   clk       : clock. All state changes on the rising edge.
//   reset     : asynchronous, active-low. Clears q, ovf and bad_load.
//   clr       : synchronous clear of q, ovf and bad_load (highest priority).
//   load      : synchronous parallel load from d. Non-decimal digits load as 0.
//   d         : packed BCD load value.
//   en        : count enable.
//   up        : direction. 1 = increment, 0 = decrement.
//   q         : registered packed BCD count.
//   tc        : combinational terminal count. It is high in the cycle before
//               a wrap.
//   ovf       : sticky flag. It is set on the edge where the counter wraps.
//   bad_load  : sticky flag. It is set on a load that held any digit 10..15.
//
// Handshake: none. Every input is sampled on each rising edge. Edge priority
// is clr > load > en > hold.
// -----------------------------------------------------------------------------
module bcd_counter_ndigit #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   d,
  input  logic                  en,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  ovf,
  output logic                  bad_load
);

  logic [4*DIGITS-1:0] r_q;
  logic                r_ovf;
  logic                r_bad_load;

  logic [4*DIGITS-1:0] w_q_inc;
  logic [4*DIGITS-1:0] w_q_dec;
  logic [4*DIGITS-1:0] w_d_clean;
  logic [DIGITS-1:0]   w_d_bad;
  logic [4*DIGITS-1:0] w_q_next;
  logic                w_ovf_next;
  logic                w_bad_next;

  // w_all9[k] is high when every digit below k is 9. That is the ripple
  // carry into digit k. w_all0 is the matching ripple borrow.
  // Index DIGITS covers the whole counter.
  logic [DIGITS:0]     w_all9;
  logic [DIGITS:0]     w_all0;

  assign w_all9[0] = 1'b1;
  assign w_all0[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [3:0] w_dig;
    logic [3:0] w_d_dig;

    assign w_dig   = r_q[4*k +: 4];
    assign w_d_dig = d[4*k +: 4];

    assign w_all9[k+1] = w_all9[k] & (w_dig == 4'd9);
    assign w_all0[k+1] = w_all0[k] & (w_dig == 4'd0);

    // Increment. The digit steps only when the lower digits carry,
    // and 9 wraps to 0.
    assign w_q_inc[4*k +: 4] = !w_all9[k]       ? w_dig :
                               (w_dig == 4'd9)  ? 4'd0  : w_dig + 4'd1;

    // Decrement. The digit steps only when the lower digits borrow,
    // and 0 wraps to 9.
    assign w_q_dec[4*k +: 4] = !w_all0[k]       ? w_dig :
                               (w_dig == 4'd0)  ? 4'd9  : w_dig - 4'd1;

    // Load path. A non-decimal digit is replaced by 0 so that q never
    // shows A..F. The replacement is reported through bad_load.
    assign w_d_bad[k]          = (w_d_dig > 4'd9);
    assign w_d_clean[4*k +: 4] = w_d_bad[k] ? 4'd0 : w_d_dig;
  end

  // Next-state selection.
  always_comb begin
    w_q_next   = r_q;
    w_ovf_next = r_ovf;
    w_bad_next = r_bad_load;
    if (clr) begin
      w_q_next   = '0;
      w_ovf_next = 1'b0;
      w_bad_next = 1'b0;
    end else if (load) begin
      w_q_next = w_d_clean;
      if (|w_d_bad) begin
        w_bad_next = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        w_q_next = w_q_inc;
        if (w_all9[DIGITS]) begin
          w_ovf_next = 1'b1;
        end
      end else begin
        w_q_next = w_q_dec;
        if (w_all0[DIGITS]) begin
          w_ovf_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q        <= '0;
      r_ovf      <= 1'b0;
      r_bad_load <= 1'b0;
    end else begin
      r_q        <= w_q_next;
      r_ovf      <= w_ovf_next;
      r_bad_load <= w_bad_next;
    end
  end

  assign q        = r_q;
  assign ovf      = r_ovf;
  assign bad_load = r_bad_load;

  // Terminal count looks at the current q. A downstream stage whose en is
  // driven by tc therefore counts on the same edge that this stage wraps.
  assign tc = en & ((up & w_all9[DIGITS]) | (~up & w_all0[DIGITS]));

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
module tb_bcd_counter_ndigit;

  logic        clk;
  logic        reset;
  logic        clr;
  logic        load;
  logic [15:0] d;
  logic        en;
  logic        up;
  logic [15:0] q;
  logic        tc;
  logic        ovf;
  logic        bad_load;

  // cascade pair (DIGITS=1)
  logic       c_en;
  logic       c_up;
  logic       c_clr;
  logic       c_load;
  logic [3:0] c_d;
  logic [3:0] c_q1, c_q2;
  logic       c_tc1, c_tc2, c_ovf1, c_ovf2, c_bad1, c_bad2;

  int n_checks;
  int n_fail;

  bcd_counter_ndigit #(.DIGITS(4)) dut (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .d(d), .en(en), .up(up),
    .q(q), .tc(tc), .ovf(ovf), .bad_load(bad_load)
  );

  bcd_counter_ndigit #(.DIGITS(1)) stage1 (
    .clk(clk), .reset(reset), .clr(c_clr), .load(c_load), .d(c_d), .en(c_en), .up(c_up),
    .q(c_q1), .tc(c_tc1), .ovf(c_ovf1), .bad_load(c_bad1)
  );

  bcd_counter_ndigit #(.DIGITS(1)) stage2 (
    .clk(clk), .reset(reset), .clr(c_clr), .load(c_load), .d(c_d), .en(c_tc1), .up(c_up),
    .q(c_q2), .tc(c_tc2), .ovf(c_ovf2), .bad_load(c_bad2)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int v;
    v = n;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] val);
    load = 1'b1; d = val; en = 1'b0; clr = 1'b0;
    step();
    load = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1; load = 1'b0; en = 1'b0;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    logic        bad_digit;
    #1;
    n_checks++;
    if (q !== 16'h0000 || ovf !== 1'b0 || bad_load !== 1'b0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: q=%h ovf=%b bad=%b tc=%b expected 0000 0 0 0", q, ovf, bad_load, tc);
    end
    reset = 1'b1;
    step();
    do_load(16'h0042);
    n_checks++;
    if (q !== 16'h0042) begin
      n_fail++;
      $display("FAIL reset_preload: q=%h expected 0042", q);
    end
    // assert reset mid-cycle; q must clear before the next edge
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (q !== 16'h0000 || ovf !== 1'b0 || bad_load !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: q=%h ovf=%b bad=%b expected 0000 0 0", q, ovf, bad_load);
    end
    en = 1'b1; up = 1'b0;
    #1;
    n_checks++;
    if (tc !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tc_down: tc=%b expected 1", tc);
    end
    en = 1'b0; up = 1'b1;
    step();
    reset = 1'b1;
    en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      exp = to_bcd(i);
      bad_digit = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (q[4*k +: 4] > 4'd9) bad_digit = 1'b1;
      end
      n_checks++;
      if (q !== exp || bad_digit) begin
        n_fail++;
        $display("FAIL reset_count_%0d: q=%h expected %h", i, q, exp);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_up_wrap();
    do_load(16'h9998);
    en = 1'b1; up = 1'b1;
    step();
    n_checks++;
    if (q !== 16'h9999 || tc !== 1'b1) begin
      n_fail++;
      $display("FAIL up_wrap_9999: q=%h tc=%b expected 9999 1", q, tc);
    end
    step();
    n_checks++;
    if (q !== 16'h0000 || ovf !== 1'b1 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL up_wrap_0000: q=%h ovf=%b tc=%b expected 0000 1 0", q, ovf, tc);
    end
    en = 1'b0;
    do_load(16'h0123);
    n_checks++;
    if (q !== 16'h0123 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky_load: q=%h ovf=%b expected 0123 1", q, ovf);
    end
    do_clr();
    n_checks++;
    if (q !== 16'h0000 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL up_wrap_clr: q=%h ovf=%b expected 0000 0", q, ovf);
    end
  endtask

  task automatic test_down();
    do_load(16'h0100);
    en = 1'b1; up = 1'b0;
    step();
    n_checks++;
    if (q !== 16'h0099) begin
      n_fail++;
      $display("FAIL down_0099: q=%h expected 0099", q);
    end
    step();
    n_checks++;
    if (q !== 16'h0098 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL down_0098: q=%h ovf=%b expected 0098 0", q, ovf);
    end
    do_load(16'h0000);
    en = 1'b1; up = 1'b0;
    #1;
    n_checks++;
    if (tc !== 1'b1) begin
      n_fail++;
      $display("FAIL down_tc: tc=%b expected 1", tc);
    end
    step();
    n_checks++;
    if (q !== 16'h9999 || ovf !== 1'b1 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL down_wrap: q=%h ovf=%b tc=%b expected 9999 1 0", q, ovf, tc);
    end
    en = 1'b0;
    do_clr();
  endtask

  task automatic test_bad_load();
    logic [15:0] exp;
    do_load(16'h1A3F);
    n_checks++;
    if (q !== 16'h1030 || bad_load !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_load_value: q=%h bad=%b expected 1030 1", q, bad_load);
    end
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      exp = to_bcd(1030 + i);
      n_checks++;
      if (q !== exp || bad_load !== 1'b1) begin
        n_fail++;
        $display("FAIL bad_load_persist_%0d: q=%h bad=%b expected %h 1", i, q, bad_load, exp);
      end
    end
    en = 1'b0;
    do_clr();
    n_checks++;
    if (q !== 16'h0000 || bad_load !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_load_clr: q=%h bad=%b expected 0000 0", q, bad_load);
    end
    do_load(16'h5987);
    n_checks++;
    if (q !== 16'h5987 || bad_load !== 1'b0) begin
      n_fail++;
      $display("FAIL good_load: q=%h bad=%b expected 5987 0", q, bad_load);
    end
    do_clr();
  endtask

  task automatic test_priority();
    do_load(16'h0005);
    clr = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1; d = 16'h0777;
    step();
    n_checks++;
    if (q !== 16'h0000) begin
      n_fail++;
      $display("FAIL prio_clr: q=%h expected 0000", q);
    end
    clr = 1'b0;
    step();
    n_checks++;
    if (q !== 16'h0777) begin
      n_fail++;
      $display("FAIL prio_load: q=%h expected 0777", q);
    end
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (q !== 16'h0777) begin
        n_fail++;
        $display("FAIL prio_hold_%0d: q=%h expected 0777", i, q);
      end
    end
  endtask

  task automatic test_cascade();
    int exp_lo;
    int exp_hi;
    c_en = 1'b1; c_up = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      step();
      exp_lo = i % 10;
      exp_hi = i / 10;
      n_checks++;
      if (c_q1 !== 4'(exp_lo) || c_q2 !== 4'(exp_hi)) begin
        n_fail++;
        $display("FAIL cascade_%0d: value=%h%h expected %0d%0d", i, c_q2, c_q1, exp_hi, exp_lo);
      end
      n_checks++;
      if (c_tc1 !== (exp_lo == 9)) begin
        n_fail++;
        $display("FAIL cascade_tc_%0d: tc=%b expected %b", i, c_tc1, (exp_lo == 9));
      end
    end
    c_en = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset  = 1'b0;
    clr    = 1'b0;
    load   = 1'b0;
    d      = '0;
    en     = 1'b0;
    up     = 1'b1;
    c_en   = 1'b0;
    c_up   = 1'b1;
    c_clr  = 1'b0;
    c_load = 1'b0;
    c_d    = '0;
    test_reset();
    do_clr();
    test_up_wrap();
    test_down();
    test_bad_load();
    test_priority();
    test_cascade();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
